// File: rtl/neuron_accum.sv
// neuron_accum: sums four signed 4-bit lane products per beat into a saturating accumulator
// and quantises the completed frame to 4 bits. Define NEURON_ACCUM_RELU_EN to zero negative outputs.
module neuron_accum #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] QMax   = ACC_W'(7);
  localparam logic signed [ACC_W-1:0] QMin   = ACC_W'(-8);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    sat_q;

  logic signed [5:0]       lane_sum;
  logic signed [ACC_W:0]   sum_ext;
  logic                    acc_clamp;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic [3:0]              quant;
  logic                    q_clamp;

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);

  always_comb begin
    lane_sum = {{2{in_data[15]}}, in_data[15:12]} + {{2{in_data[11]}}, in_data[11:8]}
             + {{2{in_data[7]}},  in_data[7:4]}   + {{2{in_data[3]}},  in_data[3:0]};
    // One guard bit: overflow shows as disagreement between the top two bits.
    sum_ext   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-5){lane_sum[5]}}, lane_sum};
    acc_clamp = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (acc_clamp) begin
      acc_d = sum_ext[ACC_W] ? AccMin : AccMax;
    end else begin
      acc_d = sum_ext[ACC_W-1:0];
    end

    shifted = acc_d >>> SHIFT;
    q_clamp = 1'b0;
    if (shifted > QMax) begin
      quant   = 4'b0111;
      q_clamp = 1'b1;
    end else if (shifted < QMin) begin
      quant   = 4'b1000;
      q_clamp = 1'b1;
    end else begin
      quant = shifted[3:0];
    end
`ifdef NEURON_ACCUM_RELU_EN
    if (quant[3]) begin
      quant = 4'b0000;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAcc;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      out_acc  <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid) begin
            acc_q <= acc_d;
            sat_q <= sat_q | acc_clamp;
            if (in_last) begin
              state_q  <= StHold;
              out_acc  <= acc_d;
              out_data <= quant;
              out_sat  <= sat_q | acc_clamp | q_clamp;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q <= StAcc;
            acc_q   <= '0;
            sat_q   <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum.sv
// Scoreboard bench for neuron_accum: two instances (ACC_W=8/SHIFT=0 and ACC_W=12/SHIFT=2)
// share stimulus and are checked against an integer reference model.
module tb_neuron_accum;

  localparam int unsigned WA = 8;
  localparam int unsigned SA = 0;
  localparam int unsigned WB = 12;
  localparam int unsigned SB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_last;
  logic          out_ready = 1'b0;
  logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [3:0]    out_data_a, out_data_b;
  logic [WA-1:0] out_acc_a;
  logic [WB-1:0] out_acc_b;
  logic          out_sat_a, out_sat_b;
  bit            bp_force = 1'b0;

  typedef struct { int acc; int data; bit sat; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  int   m_acc_a, m_acc_b;
  bit   m_sat_a, m_sat_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  neuron_accum #(.ACC_W(WA), .SHIFT(SA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_acc(out_acc_a), .out_sat(out_sat_a)
  );

  neuron_accum #(.ACC_W(WB), .SHIFT(SB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_acc(out_acc_b), .out_sat(out_sat_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the lane values.
  function automatic int lane_total(input logic [15:0] d);
    int s = 0;
    logic [15:0] v = d;
    for (int i = 0; i < 4; i++) begin
      logic signed [3:0] n;
      n = v[15 - 4*i -: 4];
      s += int'(n);
    end
    return s;
  endfunction

  function automatic int sat_add(input int w, input int acc, input int s, output bit clamped);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int r  = acc + s;
    clamped = 1'b0;
    if (r > hi) begin r = hi; clamped = 1'b1; end
    if (r < lo) begin r = lo; clamped = 1'b1; end
    return r;
  endfunction

  function automatic exp_t finish_frame(input int sh, input int acc, input bit sat);
    exp_t e;
    int q = acc >>> sh;
    e.acc = acc;
    e.sat = sat;
    if (q > 7)  begin q = 7;  e.sat = 1'b1; end
    if (q < -8) begin q = -8; e.sat = 1'b1; end
`ifdef NEURON_ACCUM_RELU_EN
    if (q < 0) q = 0;
`endif
    e.data = q;
    return e;
  endfunction

  always begin
    @(posedge clk);
    #2;
    out_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_a && out_ready) begin
      if (q_a.size() == 0) check("unexpected_out_a", 1, 0);
      else begin
        e = q_a.pop_front();
        check("acc_a", $signed(out_acc_a), e.acc);
        check("data_a", $signed(out_data_a), e.data);
        check("sat_a", int'(out_sat_a), int'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_b && out_ready) begin
      if (q_b.size() == 0) check("unexpected_out_b", 1, 0);
      else begin
        e = q_b.pop_front();
        check("acc_b", $signed(out_acc_b), e.acc);
        check("data_b", $signed(out_data_b), e.data);
        check("sat_b", int'(out_sat_b), int'(e.sat));
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    bit c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready_a && in_ready_b) break;
      n++;
      if (n > 500) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_acc_a = sat_add(WA, m_acc_a, lane_total(d), c);
    m_sat_a |= c;
    m_acc_b = sat_add(WB, m_acc_b, lane_total(d), c);
    m_sat_b |= c;
    if (last) begin
      q_a.push_back(finish_frame(SA, m_acc_a, m_sat_a));
      q_b.push_back(finish_frame(SB, m_acc_b, m_sat_b));
      m_acc_a = 0; m_sat_a = 1'b0; m_acc_b = 0; m_sat_b = 1'b0;
      @(negedge clk);
      check("out_valid_latency_a", int'(out_valid_a), 1);
      check("out_valid_latency_b", int'(out_valid_b), 1);
      check("in_ready_hold", int'(in_ready_a), 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    q_a.delete();
    q_b.delete();
    m_acc_a = 0; m_sat_a = 1'b0; m_acc_b = 0; m_sat_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid_a | out_valid_b), 0);
    check("rst_in_ready", int'(in_ready_a & in_ready_b), 1);
    check("rst_out_acc", int'(out_acc_a) + int'(out_acc_b), 0);
    check("rst_out_data", int'(out_data_a) + int'(out_data_b), 0);
    check("rst_out_sat", int'(out_sat_a | out_sat_b), 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    logic [WA-1:0] ca;
    logic [WB-1:0] cb;
    logic [3:0]    da, db;
    logic          sa, sb;
    int            nb;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    do_reset();

    send(16'h1111, 1'b1);
    send(16'h7777, 1'b0); send(16'h7777, 1'b0); send(16'h7777, 1'b1);
    send(16'h8888, 1'b1);
    for (int i = 0; i < 5; i++) send(16'h7777, i == 4);
    drain();

    // Backpressure: outputs frozen, inputs ignored while held.
    bp_force = 1'b1;
    send(16'h3333, 1'b1);
    ca = out_acc_a; cb = out_acc_b; da = out_data_a; db = out_data_b;
    sa = out_sat_a; sb = out_sat_b;
    in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'($urandom());
      @(negedge clk);
      check("bp_in_ready", int'(in_ready_a | in_ready_b), 0);
      check("bp_out_valid", int'(out_valid_a & out_valid_b), 1);
      check("bp_stable_a", int'(out_acc_a != ca || out_data_a != da || out_sat_a != sa), 0);
      check("bp_stable_b", int'(out_acc_b != cb || out_data_b != db || out_sat_b != sb), 0);
    end
    in_valid = 1'b0;
    bp_force = 1'b0;
    send(16'h1111, 1'b1);
    drain();

    // Reset mid-frame discards the partial sum.
    send(16'h1111, 1'b0); send(16'h1111, 1'b0);
    do_reset();
    send(16'h2222, 1'b1);
    drain();

    // Reset while holding a result discards it.
    bp_force = 1'b1;
    send(16'h1234, 1'b1);
    do_reset();
    bp_force = 1'b0;

    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) send(16'($urandom()), b == nb - 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_accum.md
NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 Parameter ACC_W, default 12: signed accumulator width; legal range 7..24.
REQ-002 Parameter SHIFT, default 0: arithmetic right shift applied before output quantisation; legal range 0..ACC_W-4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  16  four packed signed 4-bit lane products; lane0=[15:12], lane1=[11:8], lane2=[7:4], lane3=[3:0].
REQ-008 in_last  input  1  final beat of the current neuron frame.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_data  output  4  quantised signed neuron output, same 4-bit format as the lanes.
REQ-012 out_acc  output  ACC_W  raw signed accumulator value of the completed frame.
REQ-013 out_sat  output  1  a clamp occurred anywhere in the completed frame.

Function
REQ-014 Beat acceptance: a beat SHALL be accepted when in_valid and in_ready are both high in the same cycle.
REQ-015 Lane sum: each accepted beat SHALL produce the 6-bit signed sum of its four sign-extended lanes (range -32..28).
REQ-016 Accumulation: the lane sum SHALL be added to the signed ACC_W accumulator.
REQ-017 Accumulator saturation: the accumulator SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], never wrap.
- A clamp SHALL set the sticky frame flag.
REQ-018 FSM states: ACC and HOLD; the reset state is ACC.
- in_ready=1 only in ACC.
- out_valid=1 only in HOLD.
REQ-019 ACC -> HOLD: on an accepted beat with in_last=1.
- out_acc SHALL capture the accumulator value including that beat.
- out_valid SHALL rise the next cycle (latency 1 cycle from the last beat).
REQ-020 HOLD -> ACC: when out_ready=1.
- Accumulator and sticky flag SHALL clear to 0 on the same edge.
- in_ready SHALL rise the following cycle.
REQ-021 Output stability: while in HOLD with out_ready=0, out_data, out_acc and out_sat SHALL remain stable; in_data and in_valid are ignored.
REQ-022 Output quantisation: out_data = out_acc arithmetically shifted right by SHIFT (rounding toward minus infinity), then clamped to [-8,7].
- A clamp here SHALL also set out_sat.
REQ-023 Zero-length frames: none exist; a single accepted beat with in_last=1 is a complete frame.
REQ-024 Idle cycles: in_valid=0 cycles inside a frame SHALL leave the accumulator unchanged.

Reset
REQ-025 On rst=1, the block SHALL enter ACC and clear the accumulator and sticky flag.
- Output reset values: out_valid=0, out_data=0, out_acc=0, out_sat=0; in_ready=1 from the first cycle after rst deasserts.
REQ-026 Reset mid-frame or in HOLD SHALL discard the partial or pending result with no output.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-028 Macro NEURON_ACCUM_RELU_EN.
- Defined: a negative quantised value SHALL be forced to out_data=0 after clamping; out_acc stays raw; ReLU does not set out_sat.
- Undefined: out_data carries the signed clamped value.

Verification
REQ-029 Single beat: in_data=16'h1111, in_last=1 -> next cycle out_valid=1, out_acc=4, out_data=4, out_sat=0.
REQ-030 Output clamp: three beats of 16'h7777, last on the third -> out_acc=84, out_data=7, out_sat=1.
REQ-031 Negative frame: one beat 16'h8888 -> out_acc=-32, out_data=-8; with NEURON_ACCUM_RELU_EN defined, out_data=0.
REQ-032 Accumulator clamp: ACC_W=8, five beats of 16'h7777 -> out_acc=127 (not wrapped), out_sat=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next frame starts from 0.
REQ-034 Reset mid-frame: two beats of 16'h1111 without in_last, then rst pulse, then one beat of 16'h2222 with last -> out_acc=8.
